// File: rtl/note_scroll_buffer_pkg.sv
// note_scroll_buffer_pkg: shared note width, staff geometry defaults and scroll FSM states.
// The geometry defaults are also used by the VGA staff renderer.
package note_scroll_buffer_pkg;

    localparam int NOTE_W            = 6;
    localparam int DEF_SLOT_WIDTH_PX = 32;
    localparam int DEF_STEP_PX       = 4;

    typedef enum logic [1:0] {
        IDLE,
        ANIM,
        COMMIT
    } state_e;

endpackage

// File: rtl/note_scroll_buffer_fifo.sv
// note_fifo: synchronous pending-note FIFO with wrap-bit pointers.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module note_fifo
    import note_scroll_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [NOTE_W-1:0] din,
    output logic [NOTE_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(DEPTH);

    logic [NOTE_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic              do_push;
    logic              do_pop;

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/note_scroll_buffer.sv
// note_scroll_buffer: history of the last NUM_SLOTS staff notes with a queued,
// frame-paced left-scroll animation and a combinational slot read port.
module note_scroll_buffer
    import note_scroll_buffer_pkg::*;
#(
    parameter int NUM_SLOTS     = 8,
    parameter int SLOT_WIDTH_PX = DEF_SLOT_WIDTH_PX,
    parameter int STEP_PX       = DEF_STEP_PX,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NOTE_W-1:0]                notaActual,
    input  logic                             movimientoIzquierda,
    input  logic                             movimientoDerecha,
    input  logic                             frame_tick,
    input  logic [$clog2(NUM_SLOTS)-1:0]     slot_index,
    output logic [NOTE_W-1:0]                slot_note,
    output logic                             slot_valid,
    output logic [$clog2(SLOT_WIDTH_PX)-1:0] scroll_offset,
    output logic                             busy,
    output logic                             overflow
);

    localparam int OFF_W = $clog2(SLOT_WIDTH_PX);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(SLOT_WIDTH_PX - STEP_PX);
    localparam logic [OFF_W-1:0] STEP     = OFF_W'(STEP_PX);

    state_e                             state_q, state_d;
    logic [OFF_W-1:0]                   off_q, off_d;
    logic [NOTE_W-1:0]                  cur_q, cur_d;
    logic [NUM_SLOTS-1:0][NOTE_W-1:0]   note_q, note_d;
    logic [NUM_SLOTS-1:0]               valid_q, valid_d;
    logic                               ovf_q, ovf_d;
    logic                               pop;
    logic                               empty;
    logic                               full;
    logic [NOTE_W-1:0]                  fifo_dout;

    note_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (movimientoIzquierda),
        .pop   (pop),
        .din   (notaActual),
        .dout  (fifo_dout),
        .empty (empty),
        .full  (full)
    );

    assign pop           = (state_q == IDLE) && !empty;
    assign busy          = (state_q != IDLE) || !empty;
    assign overflow      = ovf_q;
    assign scroll_offset = off_q;
    assign slot_note     = note_q[slot_index];
    assign slot_valid    = valid_q[slot_index];

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        cur_d   = cur_q;
        note_d  = note_q;
        valid_d = valid_q;
        ovf_d   = ovf_q || (movimientoIzquierda && full && !pop);
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    cur_d   = fifo_dout;
                    off_d   = '0;
                    state_d = ANIM;
                end else if (movimientoDerecha && !movimientoIzquierda) begin
                    note_d  = {note_q[NUM_SLOTS-2:0], NOTE_W'(0)};
                    valid_d = {valid_q[NUM_SLOTS-2:0], 1'b0};
                end
            end
            ANIM: begin
                if (frame_tick) begin
                    state_d = (off_q == LAST_OFF) ? COMMIT : ANIM;
                    off_d   = (off_q == LAST_OFF) ? off_q : off_q + STEP;
                end
            end
            COMMIT: begin
                note_d  = {cur_q, note_q[NUM_SLOTS-1:1]};
                valid_d = {1'b1, valid_q[NUM_SLOTS-1:1]};
                off_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            off_q   <= '0;
            cur_q   <= '0;
            note_q  <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            cur_q   <= cur_d;
            note_q  <= note_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_note_scroll_buffer.sv
// tb_note_scroll_buffer: directed scenarios push expected slot/status tuples into a
// scoreboard queue; a monitor pops one per cycle, addresses the slot and compares.
module tb_note_scroll_buffer;

    typedef struct {
        int         idx;
        logic [5:0] note;
        logic       valid;
        logic [4:0] off;
        logic       busy;
        logic       ovf;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] notaActual;
    logic       movimientoIzquierda;
    logic       movimientoDerecha;
    logic       frame_tick;
    logic [2:0] slot_index = '0;
    logic [5:0] slot_note;
    logic       slot_valid;
    logic [4:0] scroll_offset;
    logic       busy;
    logic       overflow;

    exp_t  exp_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clock = ~clock;

    note_scroll_buffer dut (
        .clock               (clock),
        .reset               (reset),
        .notaActual          (notaActual),
        .movimientoIzquierda (movimientoIzquierda),
        .movimientoDerecha   (movimientoDerecha),
        .frame_tick          (frame_tick),
        .slot_index          (slot_index),
        .slot_note           (slot_note),
        .slot_valid          (slot_valid),
        .scroll_offset       (scroll_offset),
        .busy                (busy),
        .overflow            (overflow)
    );

    // Monitor: one scoreboard entry per falling edge, away from the active edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = nm_q.pop_front();
                slot_index = 3'(e.idx);
                #1;
                checks++;
                if (slot_note !== e.note || slot_valid !== e.valid || scroll_offset !== e.off ||
                    busy !== e.busy || overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL %s slot%0d: got note=%0d valid=%0b off=%0d busy=%0b ovf=%0b, want note=%0d valid=%0b off=%0d busy=%0b ovf=%0b",
                             nm, e.idx, slot_note, slot_valid, scroll_offset, busy, overflow,
                             e.note, e.valid, e.off, e.busy, e.ovf);
                end
            end
        end
    end

    task automatic chk(input string nm, input int idx, input int note, input bit v,
                       input int off, input bit b, input bit o);
        exp_t e;
        e.idx   = idx;
        e.note  = 6'(note);
        e.valid = v;
        e.off   = 5'(off);
        e.busy  = b;
        e.ovf   = o;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic sync();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sync: got %0d pending checks, want 0", exp_q.size());
            exp_q.delete();
            nm_q.delete();
        end
        #2;
    endtask

    task automatic left_pulse(input int n);
        notaActual = 6'(n);
        movimientoIzquierda = 1'b1;
        @(posedge clock);
        #2 movimientoIzquierda = 1'b0;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(posedge clock);
        #2 frame_tick = 1'b0;
    endtask

    task automatic add_note(input int n);
        left_pulse(n);
        ticks(12);
    endtask

    initial begin
        reset = 1'b1;
        notaActual = '0;
        movimientoIzquierda = 1'b0;
        movimientoDerecha = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;

        for (int i = 0; i < 8; i++) chk("reset", i, 0, 0, 0, 0, 0);
        sync();

        // single note: push, pop, 8 frame steps, commit
        left_pulse(20);
        chk("queued", 7, 0, 0, 0, 1, 0);
        sync();
        chk("anim0", 7, 0, 0, 0, 1, 0);
        sync();
        for (int k = 1; k <= 8; k++) begin
            ticks(1);
            chk(k < 8 ? "step" : "commit", 7, 0, 0, k < 8 ? 4 * k : 28, 1, 0);
            sync();
        end
        chk("land7", 7, 20, 1, 0, 0, 0);
        chk("land6", 6, 0, 0, 0, 0, 0);
        sync();

        // burst fills queue; sixth pulse overflows
        notaActual = 6'd15;
        movimientoIzquierda = 1'b1;
        for (int n = 16; n <= 19; n++) begin
            @(posedge clock);
            #2 notaActual = 6'(n);
        end
        @(posedge clock);
        #2 movimientoIzquierda = 1'b0;
        chk("queue4", 7, 20, 1, 0, 1, 0);
        sync();
        left_pulse(21);
        chk("ovf", 7, 20, 1, 0, 1, 1);
        sync();
        ticks(60);
        chk("drain2", 2, 20, 1, 0, 0, 1);
        chk("drain3", 3, 15, 1, 0, 0, 1);
        chk("drain7", 7, 19, 1, 0, 0, 1);
        chk("drain1", 1, 0, 0, 0, 0, 1);
        sync();

        // full history then one more pushes the oldest out
        for (int n = 30; n <= 37; n++) add_note(n);
        chk("fill0", 0, 30, 1, 0, 0, 1);
        chk("fill7", 7, 37, 1, 0, 0, 1);
        sync();
        add_note(40);
        chk("evict0", 0, 31, 1, 0, 0, 1);
        chk("evict6", 6, 37, 1, 0, 0, 1);
        chk("evict7", 7, 40, 1, 0, 0, 1);
        sync();

        // right shift while idle
        movimientoDerecha = 1'b1;
        @(posedge clock);
        #2 movimientoDerecha = 1'b0;
        chk("right0", 0, 0, 0, 0, 0, 1);
        chk("right1", 1, 31, 1, 0, 0, 1);
        chk("right7", 7, 37, 1, 0, 0, 1);
        sync();

        // right pulse during ANIM, then together with a left pulse: both ignored
        left_pulse(50);
        @(posedge clock);
        #2 movimientoDerecha = 1'b1;
        @(posedge clock);
        #2 movimientoDerecha = 1'b0;
        ticks(12);
        notaActual = 6'd51;
        movimientoIzquierda = 1'b1;
        movimientoDerecha = 1'b1;
        @(posedge clock);
        #2 movimientoIzquierda = 1'b0;
        movimientoDerecha = 1'b0;
        ticks(12);
        chk("ign0", 0, 32, 1, 0, 0, 1);
        chk("ign1", 1, 33, 1, 0, 0, 1);
        chk("ign6", 6, 50, 1, 0, 0, 1);
        chk("ign7", 7, 51, 1, 0, 0, 1);
        sync();

        // reset at offset 12 with one more note queued
        left_pulse(60);
        @(posedge clock);
        #2;
        ticks(3);
        left_pulse(61);
        chk("mid", 0, 32, 1, 12, 1, 1);
        sync();
        reset = 1'b1;
        chk("rst0", 0, 0, 0, 0, 0, 0);
        chk("rst7", 7, 0, 0, 0, 0, 0);
        sync();
        reset = 1'b0;
        ticks(15);
        chk("lost7", 7, 0, 0, 0, 0, 0);
        chk("lost6", 6, 0, 0, 0, 0, 0);
        sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
